// File: rtl/io_port_pkg.sv
// io_port_pkg
// Shared constants and helpers for io_port_bank and its seven-segment scanner.
//   SEG_HEX   : active-low hex-to-seven-segment table, bits 6:0 = g..a, bit 7 = dp
//   SEG_BLANK : all segments (and dp) off
//   sel_w()   : width of the shared port-select field
package io_port_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic int sel_w(input int n_in, input int n_out);
        int m;
        m = (n_in > n_out) ? n_in : n_out;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/io_port_bank_seg_scan.sv
// seg_scan
// Time-multiplexed seven-segment scanner. Each digit is held for SCAN_DIV clocks.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   value        : NUM_DIGITS packed hex nibbles, digit d = value[4d+3:4d]
//   seg          : active-low segments (dp always off)
//   dig_an       : active-low one-hot digit enable
module seg_scan
    import io_port_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_an
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIG_W-1:0]      dig_q, dig_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            nib;

    // seg and dig_an are both derived from the next digit index, so they
    // switch on the same edge and a digit never shows its neighbour's pattern.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        dig_d = dig_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            dig_d = (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end
        nib   = value[{dig_d, 2'b00} +: 4];
        // Force dp off regardless of the table contents.
        seg_d = SEG_HEX[nib] | (SEG_BLANK & 8'h80);
        an_d  = ~(NUM_DIGITS'(1) << dig_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            dig_q <= '0;
            seg_q <= SEG_HEX[0];
            an_q  <= ~NUM_DIGITS'(1);
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg    = seg_q;
    assign dig_an = an_q;

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank
// Bank of strobe-captured input ports and bus-writable output ports sharing
// one port-select field, plus a seven-segment scan of output port 0.
// Optional feature macro: IO_PORT_BANK_IRQ_EN (adds irq_mask input, irq output).
// Ports:
//   clk, reset_n  : clock, async active-low reset
//   in_pins       : NUM_IN packed input words; in_strobe : async capture strobes
//   port_sel      : shared port index; inport_out : read request; outport_in : write strobe
//   bus_data_in   : write data; bus_data_out : combinational read data
//   in_valid      : data available; in_overrun : sticky overwrite-before-read
//   out_pins      : NUM_OUT packed output registers
//   seg, dig_an   : active-low seven-segment drive
//   irq_mask, irq : (optional) masked OR of in_valid, registered
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_IN      = 2,
    parameter int NUM_OUT     = 2,
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV    = 1000,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = sel_w(NUM_IN, NUM_OUT)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  in_pins,
    input  logic [NUM_IN-1:0]             in_strobe,
    input  logic [SEL_W-1:0]              port_sel,
    input  logic                          inport_out,
    input  logic                          outport_in,
    input  logic [DATA_WIDTH-1:0]         bus_data_in,
    output logic [DATA_WIDTH-1:0]         bus_data_out,
    output logic [NUM_IN-1:0]             in_valid,
    output logic [NUM_IN-1:0]             in_overrun,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_pins,
    output logic [7:0]                    seg,
    output logic [NUM_DIGITS-1:0]         dig_an
`ifdef IO_PORT_BANK_IRQ_EN
    ,
    input  logic [NUM_IN-1:0]             irq_mask,
    output logic                          irq
`endif
);

    logic [SYNC_STAGES-1:0] sync_q [NUM_IN];
    logic [NUM_IN-1:0]      prev_q;
    logic [NUM_IN-1:0]      cap;
    logic [NUM_IN-1:0]      rd_hit;

    logic [DATA_WIDTH-1:0]  in_reg_q  [NUM_IN];
    logic [DATA_WIDTH-1:0]  in_reg_d  [NUM_IN];
    logic [NUM_IN-1:0]      valid_q, valid_d;
    logic [NUM_IN-1:0]      ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0]  out_reg_q [NUM_OUT];
    logic [DATA_WIDTH-1:0]  out_reg_d [NUM_OUT];

    logic [31:0]            sel_ext;
    logic                   rd_en;
    logic                   wr_en;

    assign sel_ext = 32'(port_sel);
    assign rd_en   = inport_out && (sel_ext < NUM_IN);
    assign wr_en   = outport_in && (sel_ext < NUM_OUT);

    assign bus_data_out = rd_en ? in_reg_q[port_sel] : '0;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            cap[i]      = sync_q[i][SYNC_STAGES-1] & ~prev_q[i];
            rd_hit[i]   = rd_en && (sel_ext == i);
            in_reg_d[i] = cap[i] ? in_pins[i*DATA_WIDTH +: DATA_WIDTH] : in_reg_q[i];
            // Capture beats a same-cycle read: data stays valid, but the
            // overrun is cleared because the previous word was consumed.
            valid_d[i]  = cap[i] | (valid_q[i] & ~rd_hit[i]);
            ovr_d[i]    = ~rd_hit[i] & (ovr_q[i] | (cap[i] & valid_q[i]));
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            out_reg_d[j] = (wr_en && (sel_ext == j)) ? bus_data_in : out_reg_q[j];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                sync_q[i]   <= '0;
                in_reg_q[i] <= '0;
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                out_reg_q[j] <= '0;
            end
            prev_q  <= '0;
            valid_q <= '0;
            ovr_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                sync_q[i]   <= {sync_q[i][SYNC_STAGES-2:0], in_strobe[i]};
                prev_q[i]   <= sync_q[i][SYNC_STAGES-1];
                in_reg_q[i] <= in_reg_d[i];
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                out_reg_q[j] <= out_reg_d[j];
            end
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign in_valid   = valid_q;
    assign in_overrun = ovr_q;

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        assign out_pins[j*DATA_WIDTH +: DATA_WIDTH] = out_reg_q[j];
    end

`ifdef IO_PORT_BANK_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(valid_q & irq_mask);
        end
    end

    assign irq = irq_q;
`endif

    seg_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_seg_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (out_reg_q[0][4*NUM_DIGITS-1:0]),
        .seg     (seg),
        .dig_an  (dig_an)
    );

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank. Three input ports and two output ports give
// a two-bit port_sel so that indices beyond NUM_OUT (and NUM_IN) can be driven.
module tb_io_port_bank;

    localparam int DW = 32;
    localparam int NI = 3;
    localparam int NO = 2;
    localparam int ND = 8;
    localparam int SD = 1000;
    localparam int SS = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NI*DW-1:0]  in_pins;
    logic [NI-1:0]     in_strobe;
    logic [1:0]        port_sel;
    logic              inport_out;
    logic              outport_in;
    logic [DW-1:0]     bus_data_in;
    logic [DW-1:0]     bus_data_out;
    logic [NI-1:0]     in_valid;
    logic [NI-1:0]     in_overrun;
    logic [NO*DW-1:0]  out_pins;
    logic [7:0]        seg;
    logic [ND-1:0]     dig_an;
`ifdef IO_PORT_BANK_IRQ_EN
    logic [NI-1:0]     irq_mask;
    logic              irq;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_seg [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    always #5 clk = ~clk;

    io_port_bank #(
        .DATA_WIDTH  (DW),
        .NUM_IN      (NI),
        .NUM_OUT     (NO),
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_pins      (in_pins),
        .in_strobe    (in_strobe),
        .port_sel     (port_sel),
        .inport_out   (inport_out),
        .outport_in   (outport_in),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .in_valid     (in_valid),
        .in_overrun   (in_overrun),
        .out_pins     (out_pins),
        .seg          (seg),
        .dig_an       (dig_an)
`ifdef IO_PORT_BANK_IRQ_EN
        ,
        .irq_mask     (irq_mask),
        .irq          (irq)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_dig(input logic [7:0] target);
        int n;
        n = 0;
        while (dig_an !== target && n < 9000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_dig", 64'(dig_an), 64'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        in_pins     = '0;
        in_strobe   = '0;
        port_sel    = '0;
        inport_out  = 1'b0;
        outport_in  = 1'b0;
        bus_data_in = '0;
`ifdef IO_PORT_BANK_IRQ_EN
        irq_mask    = 3'b010;
`endif
        tick(2);

        // Reset values
        chk("rst_bus",    64'(bus_data_out), 64'h0);
        chk("rst_valid",  64'(in_valid),     64'h0);
        chk("rst_dig_an", 64'(dig_an),       64'hFE);
        chk("rst_seg",    64'(seg),          64'hC0);

        // Digit 0 held for SD edges after release
        reset_n = 1'b1;
        tick(SD - 1);
        chk("scan_hold", 64'(dig_an), 64'hFE);
        tick(1);
        chk("scan_step", 64'(dig_an), 64'hFD);
        chk("scan_seg0", 64'(seg),    64'hC0);

        // Port 1 capture latency SS+1 and read-to-clear
        in_pins[DW +: DW] = 32'hDEADBEEF;
        in_strobe[1]      = 1'b1;
        tick(SS);
        chk("p1_early", 64'(in_valid[1]), 64'h0);
        tick(1);
        chk("p1_valid", 64'(in_valid[1]), 64'h1);
        in_strobe[1] = 1'b0;
        port_sel     = 2'd1;
        inport_out   = 1'b1;
        #1;
        chk("p1_read", 64'(bus_data_out), 64'hDEADBEEF);
        tick(1);
        inport_out = 1'b0;
        chk("p1_clr_valid", 64'(in_valid[1]),   64'h0);
        chk("p1_clr_ovr",   64'(in_overrun[1]), 64'h0);

        // Read beyond NUM_IN returns zero
        port_sel   = 2'd3;
        inport_out = 1'b1;
        #1;
        chk("rd_oob", 64'(bus_data_out), 64'h0);
        tick(1);
        inport_out = 1'b0;

        // Two captures on port 0 without a read: overrun, latest data kept
        in_pins[0 +: DW] = 32'd5;
        in_strobe[0]     = 1'b1;
        tick(3);
        chk("p0_first_valid", 64'(in_valid[0]),   64'h1);
        chk("p0_first_ovr",   64'(in_overrun[0]), 64'h0);
        in_strobe[0] = 1'b0;
        tick(3);
        in_pins[0 +: DW] = 32'd9;
        in_strobe[0]     = 1'b1;
        tick(3);
        chk("p0_ovr",       64'(in_overrun[0]), 64'h1);
        chk("p0_ovr_valid", 64'(in_valid[0]),   64'h1);
        in_strobe[0] = 1'b0;
        port_sel     = 2'd0;
        inport_out   = 1'b1;
        #1;
        chk("p0_read9", 64'(bus_data_out), 64'd9);
        tick(1);
        inport_out = 1'b0;
        chk("p0_clr_valid", 64'(in_valid[0]),   64'h0);
        chk("p0_clr_ovr",   64'(in_overrun[0]), 64'h0);

        // Capture and read of port 0 in the same cycle
        tick(3);
        in_pins[0 +: DW] = 32'h33;
        in_strobe[0]     = 1'b1;
        tick(3);
        in_strobe[0] = 1'b0;
        tick(3);
        in_pins[0 +: DW] = 32'h77;
        in_strobe[0]     = 1'b1;
        tick(2);
        port_sel   = 2'd0;
        inport_out = 1'b1;
        #1;
        chk("coinc_old", 64'(bus_data_out), 64'h33);
        tick(1);
        inport_out   = 1'b0;
        in_strobe[0] = 1'b0;
        chk("coinc_valid", 64'(in_valid[0]),   64'h1);
        chk("coinc_ovr",   64'(in_overrun[0]), 64'h0);
        inport_out = 1'b1;
        #1;
        chk("coinc_new", 64'(bus_data_out), 64'h77);
        tick(1);
        inport_out = 1'b0;
        chk("coinc_clr", 64'(in_valid[0]), 64'h0);

        // Output port writes, including ignored out-of-range selects
        port_sel    = 2'd0;
        bus_data_in = 32'h12345678;
        outport_in  = 1'b1;
        tick(1);
        chk("wr_p0", 64'(out_pins[0 +: DW]), 64'h12345678);
        port_sel    = 2'd1;
        bus_data_in = 32'hAAAA5555;
        tick(1);
        chk("wr_p1", 64'(out_pins), 64'hAAAA5555_12345678);
        port_sel    = 2'd3;
        bus_data_in = 32'hFFFFFFFF;
        tick(1);
        chk("wr_sel3", 64'(out_pins), 64'hAAAA5555_12345678);
        port_sel    = 2'd2;
        bus_data_in = 32'h0BADF00D;
        tick(1);
        outport_in = 1'b0;
        chk("wr_sel2", 64'(out_pins), 64'hAAAA5555_12345678);

        // Full scan of 0x12345678: digit d shows nibble d
        for (int d = 0; d < 8; d++) begin
            wait_dig(~(8'(1) << d));
            chk($sformatf("scan_seg%0d", d), 64'(seg), 64'(exp_seg[d]));
        end

        // Async reset mid-scan with two ports valid
        in_pins[0 +: DW]  = 32'h1;
        in_pins[DW +: DW] = 32'h2;
        in_strobe         = 3'b011;
        tick(3);
        chk("both_valid", 64'(in_valid), 64'h3);
        in_strobe = '0;
        wait_dig(8'hFB);
        port_sel   = 2'd0;
        inport_out = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(in_valid),     64'h0);
        chk("arst_ovr",   64'(in_overrun),   64'h0);
        chk("arst_out",   64'(out_pins),     64'h0);
        chk("arst_dig",   64'(dig_an),       64'hFE);
        chk("arst_seg",   64'(seg),          64'hC0);
        chk("arst_bus",   64'(bus_data_out), 64'h0);
`ifdef IO_PORT_BANK_IRQ_EN
        chk("arst_irq",   64'(irq),          64'h0);
`endif
        inport_out = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        chk("post_rst_dig",   64'(dig_an),   64'hFE);
        chk("post_rst_valid", 64'(in_valid), 64'h0);

`ifdef IO_PORT_BANK_IRQ_EN
        // irq follows masked in_valid by one cycle
        in_pins[DW +: DW] = 32'hABCD;
        in_strobe[1]      = 1'b1;
        tick(3);
        chk("irq_valid", 64'(in_valid[1]), 64'h1);
        chk("irq_lag",   64'(irq),         64'h0);
        tick(1);
        chk("irq_rise",  64'(irq),         64'h1);
        in_strobe[1] = 1'b0;
        port_sel     = 2'd1;
        inport_out   = 1'b1;
        tick(1);
        inport_out = 1'b0;
        chk("irq_rd_valid", 64'(in_valid[1]), 64'h0);
        chk("irq_hold",     64'(irq),         64'h1);
        tick(1);
        chk("irq_fall",     64'(irq),         64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
